// File: rtl/progmem_pkg.sv
// Shared definitions for the progmem arbiter slice.
// Holds the progmem address window, the default timeout read data and the arbiter state encoding.
package progmem_pkg;

  // Base of the progmem window and its size in words (log2).
  localparam logic [31:0] PROGMEM_ADDR_MASK = 32'h0010_0000;
  localparam int unsigned PROGMEM_SIZE_BITS = 10;

  // EBREAK: a fetch that hits nothing traps instead of executing garbage.
  localparam logic [31:0] ERR_DATA_DEFAULT  = 32'h0010_0073;

  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } state_e;

endpackage

// File: rtl/progmem_arbiter_if.sv
// Valid/ready read bus used for both requesting masters and the progmem port.
//   valid : request, held with a stable addr until ready
//   addr  : byte address
//   ready : one-cycle completion
//   rdata : read data, meaningful only with ready
// Modport master issues requests; modport slave answers them.
interface progmem_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, output addr, input ready, input rdata);
  modport slave  (input valid, input addr, output ready, output rdata);
endinterface

// File: rtl/progmem_arbiter_rr_arb2.sv
// Two-input round-robin pick.
//   valid_i     : request vector, bit i for master i
//   last_i      : master that completed most recently
//   gnt_valid_o : at least one request present
//   gnt_idx_o   : chosen master; on a tie the one that did not go last
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_valid_o = |valid_i;
    gnt_idx_o   = 1'b0;
    unique case (valid_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/progmem_arbiter.sv
// Shares the single read-only progmem port between two masters with round-robin grant.
//   clk, rstn   : clock, asynchronous active-low reset
//   m0, m1      : requesting masters (slave side of the bus)
//   mem         : progmem port (master side of the bus)
//   timeout_err : one-cycle pulse when an access is completed by the watchdog
//   owner       : current / last granted master
// Each access is IDLE -> ACCESS ... -> IDLE. The IDLE cycle between grants swallows the
// ready progmem raises for the second ACCESS cycle of the previous grant.
module progmem_arbiter
  import progmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                clk,
  input  logic                rstn,
  progmem_arbiter_if.slave    m0,
  progmem_arbiter_if.slave    m1,
  progmem_arbiter_if.master   mem,
  output logic                timeout_err,
  output logic                owner
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             gnt_valid;
  logic             gnt_idx;
  logic             own_valid;
  logic [31:0]      own_addr;
  logic             done;
  logic [31:0]      done_data;

  rr_arb2 u_rr_arb2 (
    .valid_i     ({m1.valid, m0.valid}),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem.valid   = 1'b0;
    mem.addr    = '0;
    timeout_err = 1'b0;
    done        = 1'b0;
    done_data   = '0;
    own_valid   = owner_q ? m1.valid : m0.valid;
    own_addr    = owner_q ? m1.addr  : m0.addr;

    unique case (state_q)
      StIdle: begin
        // mem.ready is deliberately not looked at here.
        if (gnt_valid) begin
          owner_d = gnt_idx;
          cnt_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        mem.valid = 1'b1;
        mem.addr  = own_addr;
        if (!own_valid) begin
          // Owner withdrew: abandon silently, fairness history untouched.
          state_d = StIdle;
        end else if (mem.ready) begin
          done      = 1'b1;
          done_data = mem.rdata;
        end else if (cnt_q == CntMax) begin
          done        = 1'b1;
          done_data   = ERR_DATA;
          timeout_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
    endcase

    m0.ready = done & ~owner_q;
    m0.rdata = (done & ~owner_q) ? done_data : '0;
    m1.ready = done & owner_q;
    m1.rdata = (done & owner_q) ? done_data : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_progmem_arbiter.sv
module tb_progmem_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic timeout_err;
  logic owner;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  progmem_arbiter_if m0_if ();
  progmem_arbiter_if m1_if ();
  progmem_arbiter_if mem_if ();

  progmem_arbiter #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5),
    .ERR_DATA       (32'h0010_0073)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .m0          (m0_if),
    .m1          (m1_if),
    .mem         (mem_if),
    .timeout_err (timeout_err),
    .owner       (owner)
  );

  // Progmem model: 1024 words at 0x0010_0000, registered ready one cycle after valid.
  logic [31:0] pm_mem [1024];
  logic        pm_ready_q = 1'b0;
  logic [31:0] pm_rdata_q = '0;
  logic        frc_ready = 1'b0;
  logic [31:0] frc_data = '0;

  function automatic logic is_mapped(input logic [31:0] a);
    return a[31:12] == 20'h00100;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return is_mapped(a) ? pm_mem[a[11:2]] : 32'h0010_0073;
  endfunction

  always @(posedge clk) begin
    pm_ready_q <= mem_if.valid && is_mapped(mem_if.addr);
    pm_rdata_q <= pm_mem[mem_if.addr[11:2]];
  end

  assign mem_if.ready = pm_ready_q | frc_ready;
  assign mem_if.rdata = frc_ready ? frc_data : pm_rdata_q;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    m0_if.valid = 1'b0; m0_if.addr = '0;
    m1_if.valid = 1'b0; m1_if.addr = '0;
    frc_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    m0_if.valid = 1'b1; m0_if.addr = 32'h0010_0000;
    m1_if.valid = 1'b1; m1_if.addr = 32'h0010_0004;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_if.valid, mem_if.addr, m0_if.ready, m0_if.rdata, m1_if.ready, m1_if.rdata,
         timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: mem_valid=%b mem_addr=%h m0_ready=%b m1_ready=%b err=%b, want all 0",
               mem_if.valid, mem_if.addr, m0_if.ready, m1_if.ready, timeout_err);
    end
    n_checks++;
    if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %b want 0", owner); end
  endtask

  task automatic test_m0_only();
    do_reset();
    next_cycle();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0010_0000;
    #1;
    n_checks++;
    if (mem_if.valid !== 1'b0) begin n_fail++; $display("FAIL m0_c0_mem_valid: got %b want 0", mem_if.valid); end
    next_cycle();
    n_checks++;
    if (mem_if.valid !== 1'b1 || mem_if.addr !== 32'h0010_0000) begin
      n_fail++; $display("FAIL m0_c1_mem_req: valid=%b addr=%h want 1/00100000", mem_if.valid, mem_if.addr);
    end
    next_cycle();
    n_checks++;
    if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'h0000_0093) begin
      n_fail++; $display("FAIL m0_c2_done: ready=%b rdata=%h want 1/00000093", m0_if.ready, m0_if.rdata);
    end
    n_checks++;
    if (m1_if.ready !== 1'b0 || m1_if.rdata !== '0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL m0_c2_quiet: m1_ready=%b m1_rdata=%h err=%b want 0/0/0",
                         m1_if.ready, m1_if.rdata, timeout_err);
    end
    next_cycle();
    m0_if.valid = 1'b0;
    #1;
    n_checks++;
    if (m0_if.ready !== 1'b0 || mem_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL m0_c3_stale: m0_ready=%b mem_valid=%b want 0/0", m0_if.ready, mem_if.valid);
    end
  endtask

  task automatic test_both();
    do_reset();
    next_cycle();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0010_0004;
    m1_if.valid = 1'b1; m1_if.addr = 32'h0010_0008;
    #1;
    n_checks++;
    if (mem_if.valid !== 1'b0) begin n_fail++; $display("FAIL both_c0_mem_valid: got %b want 0", mem_if.valid); end
    next_cycle();
    n_checks++;
    if (mem_if.addr !== 32'h0010_0004 || owner !== 1'b0) begin
      n_fail++; $display("FAIL both_c1_grant: addr=%h owner=%b want 00100004/0", mem_if.addr, owner);
    end
    next_cycle();
    n_checks++;
    if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'hC0DE_0001 || m1_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL both_c2_m0: m0_ready=%b rdata=%h m1_ready=%b want 1/c0de0001/0",
                         m0_if.ready, m0_if.rdata, m1_if.ready);
    end
    next_cycle();
    m0_if.valid = 1'b0;
    #1;
    n_checks++;
    if (mem_if.valid !== 1'b0 || m1_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL both_c3_idle: mem_valid=%b m1_ready=%b want 0/0", mem_if.valid, m1_if.ready);
    end
    next_cycle();
    n_checks++;
    if (mem_if.addr !== 32'h0010_0008 || owner !== 1'b1) begin
      n_fail++; $display("FAIL both_c4_grant: addr=%h owner=%b want 00100008/1", mem_if.addr, owner);
    end
    next_cycle();
    n_checks++;
    if (m1_if.ready !== 1'b1 || m1_if.rdata !== 32'hC0DE_0002 || m0_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL both_c5_m1: m1_ready=%b rdata=%h m0_ready=%b want 1/c0de0002/0",
                         m1_if.ready, m1_if.rdata, m0_if.ready);
    end
    next_cycle();
    m1_if.valid = 1'b0;
  endtask

  task automatic test_fairness();
    logic [5:0] seq;
    int         n;
    seq = '0;
    n = 0;
    do_reset();
    next_cycle();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0010_0010;
    m1_if.valid = 1'b1; m1_if.addr = 32'h0010_0020;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) next_cycle();
      #1;
      if (m0_if.ready && n < 6) begin seq[n] = 1'b0; n++; end
      if (m1_if.ready && n < 6) begin seq[n] = 1'b1; n++; end
    end
    n_checks++;
    if (n != 6) begin n_fail++; $display("FAIL fair_count: got %0d grants want 6", n); end
    n_checks++;
    if (seq !== 6'b101010) begin n_fail++; $display("FAIL fair_order: got %b want 101010", seq); end
    next_cycle();
    m0_if.valid = 1'b0; m1_if.valid = 1'b0;
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    do_reset();
    next_cycle();
    m1_if.valid = 1'b1; m1_if.addr = 32'h0000_0000;
    #1;
    for (int c = 1; c < 16; c++) begin
      next_cycle();
      if (m1_if.ready !== 1'b0 || timeout_err !== 1'b0 || mem_if.valid !== 1'b1) early++;
    end
    n_checks++;
    if (early != 0) begin n_fail++; $display("FAIL to_early: %0d bad cycles want 0", early); end
    next_cycle();
    n_checks++;
    if (m1_if.ready !== 1'b1 || m1_if.rdata !== 32'h0010_0073 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL to_c16: ready=%b rdata=%h err=%b want 1/00100073/1",
                         m1_if.ready, m1_if.rdata, timeout_err);
    end
    n_checks++;
    if (m0_if.ready !== 1'b0) begin n_fail++; $display("FAIL to_c16_m0: got %b want 0", m0_if.ready); end
    next_cycle();
    m1_if.addr = 32'h0010_0008;
    #1;
    n_checks++;
    if (timeout_err !== 1'b0 || mem_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL to_c17: err=%b mem_valid=%b want 0/0", timeout_err, mem_if.valid);
    end
    next_cycle();
    next_cycle();
    n_checks++;
    if (m1_if.ready !== 1'b1 || m1_if.rdata !== 32'hC0DE_0002 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL to_recover: ready=%b rdata=%h err=%b want 1/c0de0002/0",
                         m1_if.ready, m1_if.rdata, timeout_err);
    end
    next_cycle();
    m1_if.valid = 1'b0;
  endtask

  task automatic test_ready_beats_timeout();
    do_reset();
    next_cycle();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0000_0000;
    for (int c = 1; c < 16; c++) next_cycle();
    next_cycle();
    frc_ready = 1'b1; frc_data = 32'h1234_5678;
    #1;
    n_checks++;
    if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'h1234_5678 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL race_c16: ready=%b rdata=%h err=%b want 1/12345678/0",
                         m0_if.ready, m0_if.rdata, timeout_err);
    end
    next_cycle();
    frc_ready = 1'b0; m0_if.valid = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    next_cycle();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0010_0004;
    next_cycle();
    n_checks++;
    if (mem_if.valid !== 1'b1) begin n_fail++; $display("FAIL rst_c1_access: got %b want 1", mem_if.valid); end
    next_cycle();
    n_checks++;
    if (m0_if.ready !== 1'b1) begin n_fail++; $display("FAIL rst_c2_ready: got %b want 1", m0_if.ready); end
    #1 rstn = 1'b0;
    #1;
    n_checks++;
    if ({mem_if.valid, mem_if.addr, m0_if.ready, m0_if.rdata, m1_if.ready, timeout_err, owner} !== '0) begin
      n_fail++; $display("FAIL rst_async: mem_valid=%b m0_ready=%b m0_rdata=%h err=%b want 0",
                         mem_if.valid, m0_if.ready, m0_if.rdata, timeout_err);
    end
    @(negedge clk);
    #1 rstn = 1'b1;
    #1;
    n_checks++;
    if (m0_if.ready !== 1'b0 || mem_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_stale: m0_ready=%b mem_valid=%b want 0/0", m0_if.ready, mem_if.valid);
    end
    next_cycle();
    n_checks++;
    if (mem_if.valid !== 1'b1 || owner !== 1'b0 || m0_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_regrant: mem_valid=%b owner=%b ready=%b want 1/0/0",
                         mem_if.valid, owner, m0_if.ready);
    end
    next_cycle();
    n_checks++;
    if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'hC0DE_0001) begin
      n_fail++; $display("FAIL rst_done: ready=%b rdata=%h want 1/c0de0001", m0_if.ready, m0_if.rdata);
    end
    next_cycle();
    m0_if.valid = 1'b0;
  endtask

  task automatic test_random_stale();
    logic        vld [2];
    logic [31:0] adr [2];
    int          done_cnt;
    int          cyc;
    vld[0] = 1'b0; vld[1] = 1'b0; adr[0] = '0; adr[1] = '0;
    done_cnt = 0;
    cyc = 0;
    do_reset();
    next_cycle();
    while (done_cnt < 1000 && cyc < 20000) begin
      for (int i = 0; i < 2; i++) begin
        if (!vld[i] && $urandom_range(0, 3) != 0) begin
          vld[i] = 1'b1;
          adr[i] = ($urandom_range(0, 49) == 0) ? 32'h0000_0000
                 : (32'h0010_0000 | (32'($urandom_range(0, 1023)) << 2));
        end
      end
      m0_if.valid = vld[0]; m0_if.addr = adr[0];
      m1_if.valid = vld[1]; m1_if.addr = adr[1];
      #1;
      n_checks++;
      if (!mem_if.valid && (m0_if.ready || m1_if.ready)) begin
        n_fail++; $display("FAIL rnd_idle_ready: cycle %0d m0=%b m1=%b want 0/0", cyc, m0_if.ready, m1_if.ready);
      end
      n_checks++;
      if (m0_if.ready && m1_if.ready) begin
        n_fail++; $display("FAIL rnd_both_ready: cycle %0d got 1/1 want at most one", cyc);
      end
      if (m0_if.ready) begin
        n_checks++;
        if (!vld[0] || m0_if.rdata !== exp_word(adr[0])) begin
          n_fail++; $display("FAIL rnd_m0_data: addr=%h got %h want %h", adr[0], m0_if.rdata, exp_word(adr[0]));
        end
        vld[0] = 1'b0;
        done_cnt++;
      end
      if (m1_if.ready) begin
        n_checks++;
        if (!vld[1] || m1_if.rdata !== exp_word(adr[1])) begin
          n_fail++; $display("FAIL rnd_m1_data: addr=%h got %h want %h", adr[1], m1_if.rdata, exp_word(adr[1]));
        end
        vld[1] = 1'b0;
        done_cnt++;
      end
      next_cycle();
      cyc++;
    end
    n_checks++;
    if (done_cnt < 1000) begin
      n_fail++; $display("FAIL rnd_budget: got %0d completions want 1000", done_cnt);
    end
    m0_if.valid = 1'b0; m1_if.valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) pm_mem[i] = (i == 0) ? 32'h0000_0093 : (32'hC0DE_0000 | 32'(i));
    m0_if.valid = 1'b0; m0_if.addr = '0;
    m1_if.valid = 1'b0; m1_if.addr = '0;
    test_reset();
    test_m0_only();
    test_both();
    test_fairness();
    test_timeout();
    test_ready_beats_timeout();
    test_reset_mid_access();
    test_random_stale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want test sequence to finish");
    $fatal(1, "watchdog");
  end

endmodule
